// File: rtl/sqrt_stage.sv
// Fixed-point square root stage: floor(sqrt(in_data * 2^FRAC_W)) by MSB-first
// bit guessing. Handles one operation at a time and refuses inputs while busy.
module sqrt_stage #(
  parameter int IN_W   = 20,
  parameter int FRAC_W = 10,
  parameter int OUT_W  = (IN_W + FRAC_W) / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       dbg_state
);

  localparam int RAD_W = IN_W + FRAC_W;
  localparam int SQ_W  = 2 * OUT_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROOT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OUT_W-1:0] BASE_INIT = {1'b1, {(OUT_W-1){1'b0}}};

  // Handshake: a transfer happens on an edge where in_valid && in_ready.
  // out_valid is a single-cycle strobe with no backpressure.
  logic [1:0]       state_q, state_d;
  logic [RAD_W-1:0] rad_q, rad_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] base_q, base_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic [OUT_W-1:0] trial;
  logic [SQ_W-1:0]  trial_ext;
  logic [SQ_W-1:0]  trial_sq;
  logic [SQ_W-1:0]  rad_ext;

  assign trial     = acc_q | base_q;
  assign trial_ext = SQ_W'(trial);
  // A 2*OUT_W-bit product of two OUT_W-bit values cannot overflow.
  assign trial_sq  = trial_ext * trial_ext;
  assign rad_ext   = SQ_W'(rad_q);

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    acc_d       = acc_q;
    base_d      = base_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rad_d   = {in_data, {FRAC_W{1'b0}}};
          acc_d   = '0;
          base_d  = BASE_INIT;
          state_d = ST_ROOT;
        end
      end
      ST_ROOT: begin
        if (trial_sq == rad_ext) begin
          acc_d   = trial;
          state_d = ST_DONE;
        end else begin
          if (trial_sq < rad_ext) begin
            acc_d = trial;
          end
          base_d = base_q >> 1;
          if (base_q[0]) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        out_data_d  = acc_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rad_q       <= '0;
      acc_q       <= '0;
      base_q      <= BASE_INIT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule
